// File: rtl/decode_stage_pipe_if.sv
// Decode stage bus: fetch handshake, write-back port
// and the ID/EX bundle presented to execute.
interface decode_stage_pipe_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic [31:0]     instruction;
  logic            if_valid;
  logic            id_ready;
  logic [XLEN-1:0] wb_data;
  logic [AW-1:0]   wb_rd;
  logic            regwrite;
  logic            flush;
  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [AW-1:0]   ex_rs1;
  logic [AW-1:0]   ex_rs2;
  logic [AW-1:0]   ex_rd;
  logic [3:0]      ex_alu_ctrl;
  logic            ex_memread;

  modport master (
    output instruction,
    output if_valid,
    input  id_ready,
    output wb_data,
    output wb_rd,
    output regwrite,
    output flush,
    output ex_ready,
    input  ex_valid,
    input  ex_rs1_data,
    input  ex_rs2_data,
    input  ex_imm,
    input  ex_rs1,
    input  ex_rs2,
    input  ex_rd,
    input  ex_alu_ctrl,
    input  ex_memread
  );

  modport slave (
    input  instruction,
    input  if_valid,
    output id_ready,
    input  wb_data,
    input  wb_rd,
    input  regwrite,
    input  flush,
    input  ex_ready,
    output ex_valid,
    output ex_rs1_data,
    output ex_rs2_data,
    output ex_imm,
    output ex_rs1,
    output ex_rs2,
    output ex_rd,
    output ex_alu_ctrl,
    output ex_memread
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// Registered instruction decode stage: field decode,
// register file with optional bypass, load-use stall.

module decode_stage_pipe_dec (
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [3:0]  alu_ctrl,
  output logic        memread,
  output logic        rs1_used,
  output logic        rs2_used
);
  logic [6:0] op;
  logic [2:0] f3;
  logic       is_op;
  logic       is_opi;
  logic       is_ld;
  logic       is_st;
  logic       is_br;
  logic       is_lui;
  logic       is_aui;
  logic       is_jal;
  logic       is_jalr;

  assign op  = instr[6:0];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rd  = instr[11:7];

  assign is_op   = op == 7'b0110011;
  assign is_opi  = op == 7'b0010011;
  assign is_ld   = op == 7'b0000011;
  assign is_st   = op == 7'b0100011;
  assign is_br   = op == 7'b1100011;
  assign is_lui  = op == 7'b0110111;
  assign is_aui  = op == 7'b0010111;
  assign is_jal  = op == 7'b1101111;
  assign is_jalr = op == 7'b1100111;

  assign memread  = is_ld;
  assign rs1_used = !(is_lui || is_aui || is_jal);
  assign rs2_used = is_op || is_st || is_br;

  // immediate assembled per instruction format
  always_comb begin
    imm = '0;
    unique case (1'b1)
      is_ld, is_opi, is_jalr:
        imm = {{20{instr[31]}}, instr[31:20]};
      is_st:
        imm = {{20{instr[31]}}, instr[31:25],
               instr[11:7]};
      is_br:
        imm = {{20{instr[31]}}, instr[7],
               instr[30:25], instr[11:8], 1'b0};
      is_lui, is_aui:
        imm = {instr[31:12], 12'b0};
      is_jal:
        imm = {{12{instr[31]}}, instr[19:12],
               instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

  // ALU op: funct7[5]:funct3 for arithmetic, SUB for
  // branch compare, ADD for address/upper-imm forms
  always_comb begin
    alu_ctrl = 4'b0000;
    unique case (1'b1)
      is_op:
        alu_ctrl = {instr[30], f3};
      is_opi:
        alu_ctrl = (f3 == 3'b101) ?
                   {instr[30], f3} : {1'b0, f3};
      is_br:
        alu_ctrl = 4'b1000;
      default:
        alu_ctrl = 4'b0000;
    endcase
  end
endmodule

module decode_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input logic                clk,
  input logic                rst_n,
  decode_stage_pipe_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef struct packed {
    logic            valid;
    logic            memread;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu;
  } id_ex_t;

  logic [4:0]         f_rs1;
  logic [4:0]         f_rs2;
  logic [4:0]         f_rd;
  logic [31:0]        imm32;
  logic signed [31:0] imm_s;
  logic [3:0]         alu;
  logic               memread;
  logic               rs1_used;
  logic               rs2_used;

  decode_stage_pipe_dec u_dec (
    .instr    (bus.instruction),
    .rs1      (f_rs1),
    .rs2      (f_rs2),
    .rd       (f_rd),
    .imm      (imm32),
    .alu_ctrl (alu),
    .memread  (memread),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] imm;

  assign rs1   = f_rs1[AW-1:0];
  assign rs2   = f_rs2[AW-1:0];
  assign rd    = f_rd[AW-1:0];
  assign imm_s = imm32;
  assign imm   = XLEN'(imm_s);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  assign wr_en = bus.regwrite &&
                 (bus.wb_rd != '0);

  // register file write; x0 is never written
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // rs1 read with optional write-back forwarding
  always_comb begin
    rs1_data = regs[rs1];
    if (BYPASS != 0 && wr_en &&
        bus.wb_rd == rs1)
      rs1_data = bus.wb_data;
    if (rs1 == '0)
      rs1_data = '0;
  end

  // rs2 read with optional write-back forwarding
  always_comb begin
    rs2_data = regs[rs2];
    if (BYPASS != 0 && wr_en &&
        bus.wb_rd == rs2)
      rs2_data = bus.wb_data;
    if (rs2 == '0)
      rs2_data = '0;
  end

  id_ex_t ex_q;
  id_ex_t ex_d;
  logic   hit1;
  logic   hit2;
  logic   hazard;
  logic   advance;
  logic   accept;

  assign hit1 = rs1_used && (rs1 == ex_q.rd);
  assign hit2 = rs2_used && (rs2 == ex_q.rd);

  assign hazard = bus.if_valid &&
                  ex_q.valid &&
                  ex_q.memread &&
                  (ex_q.rd != '0) &&
                  (hit1 || hit2);

  assign advance = !ex_q.valid || bus.ex_ready;
  assign accept  = advance && bus.if_valid &&
                   !hazard;

  assign bus.id_ready = rst_n && advance &&
                        !hazard;

  // next ID/EX contents: flush, load, bubble, hold
  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d.valid = 1'b0;
    end else if (accept) begin
      ex_d.valid   = 1'b1;
      ex_d.memread = memread;
      ex_d.rs1     = rs1;
      ex_d.rs2     = rs2;
      ex_d.rd      = rd;
      ex_d.d1      = rs1_data;
      ex_d.d2      = rs2_data;
      ex_d.imm     = imm;
      ex_d.alu     = alu;
    end else if (advance) begin
      ex_d.valid   = 1'b0;
      ex_d.memread = 1'b0;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (!rst_n)
      ex_q <= '0;
    else
      ex_q <= ex_d;
  end

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_memread  = ex_q.memread;
  assign bus.ex_rs1      = ex_q.rs1;
  assign bus.ex_rs2      = ex_q.rs2;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_rs1_data = ex_q.d1;
  assign bus.ex_rs2_data = ex_q.d2;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_alu_ctrl = ex_q.alu;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios plus
// random traffic against a cycle-level reference model.
module tb_decode_stage_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] t_ins;
  logic        t_iv;
  logic        t_fl;
  logic        t_er;
  logic        t_rw;
  logic [4:0]  t_wrd;
  logic [31:0] t_wd;

  decode_stage_pipe_if #(.XLEN(32), .NREGS(32)) b0 ();
  decode_stage_pipe_if #(.XLEN(32), .NREGS(32)) b1 ();

  assign b0.instruction = t_ins;
  assign b0.if_valid    = t_iv;
  assign b0.flush       = t_fl;
  assign b0.ex_ready    = t_er;
  assign b0.regwrite    = t_rw;
  assign b0.wb_rd       = t_wrd;
  assign b0.wb_data     = t_wd;
  assign b1.instruction = t_ins;
  assign b1.if_valid    = t_iv;
  assign b1.flush       = t_fl;
  assign b1.ex_ready    = t_er;
  assign b1.regwrite    = t_rw;
  assign b1.wb_rd       = t_wrd;
  assign b1.wb_data     = t_wd;

  decode_stage_pipe #(
    .XLEN(32), .NREGS(32), .BYPASS(0)
  ) u_nb (.clk(clk), .rst_n(rst_n), .bus(b0));

  decode_stage_pipe #(
    .XLEN(32), .NREGS(32), .BYPASS(1)
  ) u_by (.clk(clk), .rst_n(rst_n), .bus(b1));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // reference state
  logic [31:0] mregs [32];
  logic        m_valid = 1'b0;
  logic        m_mr    = 1'b0;
  logic [4:0]  m_rs1   = '0;
  logic [4:0]  m_rs2   = '0;
  logic [4:0]  m_rd    = '0;
  logic [31:0] m_imm   = '0;
  logic [3:0]  m_alu   = '0;
  logic [31:0] m_d1 [2];
  logic [31:0] m_d2 [2];
  logic        last_ready;

  // spec-level decode of one instruction
  task automatic ref_dec(input logic [31:0] i,
                         output logic u1,
                         output logic u2,
                         output logic mr,
                         output logic [31:0] imm,
                         output logic [3:0] alu);
    logic [6:0] op;
    logic [2:0] f3;
    op  = i[6:0];
    f3  = i[14:12];
    u1  = !(op == 7'b0110111 || op == 7'b0010111 ||
            op == 7'b1101111);
    u2  = (op == 7'b0110011 || op == 7'b0100011 ||
           op == 7'b1100011);
    mr  = (op == 7'b0000011);
    imm = 32'd0;
    alu = 4'd0;
    case (op)
      7'b0110011: alu = {i[30], f3};
      7'b0010011: begin
        imm = 32'($signed(i[31:20]));
        alu = (f3 == 3'd5) ? {i[30], f3} : {1'b0, f3};
      end
      7'b0000011, 7'b1100111:
        imm = 32'($signed(i[31:20]));
      7'b0100011:
        imm = 32'($signed({i[31:25], i[11:7]}));
      7'b1100011: begin
        imm = 32'($signed({i[31], i[7], i[30:25],
                           i[11:8], 1'b0}));
        alu = 4'd8;
      end
      7'b0110111, 7'b0010111:
        imm = i[31:12] * 32'd4096;
      7'b1101111:
        imm = 32'($signed({i[31], i[19:12], i[20],
                           i[30:21], 1'b0}));
      default: imm = 32'd0;
    endcase
  endtask

  function automatic logic [31:0] mread(
      input logic [4:0] idx, input int byp);
    if (idx == 5'd0) return 32'd0;
    if (byp != 0 && t_rw && t_wrd != 5'd0 &&
        t_wrd == idx)
      return t_wd;
    return mregs[idx];
  endfunction

  task automatic check_ex();
    chk("ex_valid_nb", b0.ex_valid, m_valid);
    chk("ex_valid_by", b1.ex_valid, m_valid);
    if (m_valid) begin
      chk("memread", b1.ex_memread, m_mr);
      chk("rs1", b1.ex_rs1, m_rs1);
      chk("rs2", b1.ex_rs2, m_rs2);
      chk("rd", b1.ex_rd, m_rd);
      chk("imm", b1.ex_imm, m_imm);
      chk("alu", b1.ex_alu_ctrl, m_alu);
      chk("rd_nb", b0.ex_rd, m_rd);
      chk("d1_nb", b0.ex_rs1_data, m_d1[0]);
      chk("d2_nb", b0.ex_rs2_data, m_d2[0]);
      chk("d1_by", b1.ex_rs1_data, m_d1[1]);
      chk("d2_by", b1.ex_rs2_data, m_d2[1]);
    end
  endtask

  // one clock: drive, check id_ready, advance model,
  // check ID/EX outputs after the edge
  task automatic step(input logic r,
                      input logic iv,
                      input logic [31:0] ins,
                      input logic fl,
                      input logic er,
                      input logic rw,
                      input logic [4:0] wrd,
                      input logic [31:0] wd);
    logic u1, u2, mr, haz, adv;
    logic [31:0] imm;
    logic [3:0] alu;
    logic [4:0] s1, s2;
    @(negedge clk);
    rst_n = r;
    t_iv  = iv;
    t_ins = ins;
    t_fl  = fl;
    t_er  = er;
    t_rw  = rw;
    t_wrd = wrd;
    t_wd  = wd;
    #1;
    ref_dec(ins, u1, u2, mr, imm, alu);
    s1  = ins[19:15];
    s2  = ins[24:20];
    haz = iv && m_valid && m_mr && m_rd != 5'd0 &&
          ((u1 && s1 == m_rd) || (u2 && s2 == m_rd));
    adv = !m_valid || er;
    last_ready = r && adv && !haz;
    chk("id_ready_nb", b0.id_ready, last_ready);
    chk("id_ready_by", b1.id_ready, last_ready);
    if (!r) begin
      m_valid = 0; m_mr = 0; m_rs1 = 0; m_rs2 = 0;
      m_rd = 0; m_imm = 0; m_alu = 0;
      for (int b = 0; b < 2; b++) begin
        m_d1[b] = 0; m_d2[b] = 0;
      end
    end else if (fl) begin
      m_valid = 0;
    end else if (adv && iv && !haz) begin
      m_valid = 1; m_mr = mr; m_rs1 = s1;
      m_rs2 = s2; m_rd = ins[11:7];
      m_imm = imm; m_alu = alu;
      for (int b = 0; b < 2; b++) begin
        m_d1[b] = mread(s1, b);
        m_d2[b] = mread(s2, b);
      end
    end else if (adv) begin
      m_valid = 0; m_mr = 0;
    end
    if (!r) begin
      for (int k = 0; k < 32; k++) mregs[k] = 0;
    end else if (rw && wrd != 5'd0) begin
      mregs[wrd] = wd;
    end
    @(posedge clk);
    #1;
    check_ex();
  endtask

  function automatic logic [31:0] f_add(
      input logic [4:0] rd, input logic [4:0] a,
      input logic [4:0] b);
    return {7'b0, b, a, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] f_lw(
      input logic [4:0] rd, input logic [4:0] a);
    return {12'h0, a, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] f_lui(
      input logic [4:0] rd, input logic [19:0] u);
    return {u, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] rnd_ins();
    logic [31:0] i;
    logic [6:0]  op;
    case ($urandom_range(0, 8))
      0: op = 7'b0110011;
      1: op = 7'b0010011;
      2: op = 7'b0000011;
      3: op = 7'b0100011;
      4: op = 7'b1100011;
      5: op = 7'b0110111;
      6: op = 7'b0010111;
      7: op = 7'b1101111;
      default: op = 7'b1100111;
    endcase
    i = $urandom;
    i[6:0]   = op;
    i[11:7]  = 5'($urandom_range(0, 7));
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  initial begin
    rst_n = 0; t_ins = 0; t_iv = 0; t_fl = 0;
    t_er = 0; t_rw = 0; t_wrd = 0; t_wd = 0;
    for (int k = 0; k < 32; k++) mregs[k] = 0;
    for (int b = 0; b < 2; b++) begin
      m_d1[b] = 0; m_d2[b] = 0;
    end

    // reset held two cycles with a valid input
    step(0, 1, f_add(1, 2, 3), 0, 1, 0, 0, 0);
    step(0, 1, f_add(1, 2, 3), 0, 1, 0, 0, 0);
    chk("rst_ready", last_ready, 1'b1 & b1.id_ready);
    chk("rst_valid", b1.ex_valid, 0);
    chk("rst_d1", b1.ex_rs1_data, 0);
    chk("rst_imm", b1.ex_imm, 0);
    chk("rst_rd", b1.ex_rd, 0);
    chk("rst_alu", b1.ex_alu_ctrl, 0);
    for (int k = 1; k < 32; k++) begin
      step(1, 1, f_add(1, 5'(k), 5'(k)), 0, 1,
           0, 0, 0);
      chk("rst_reg", b0.ex_rs1_data, 0);
    end

    // write x5 while reading it
    step(1, 1, f_add(6, 5, 5), 0, 1, 1, 5,
         32'hDEADBEEF);
    chk("byp_rs1", b1.ex_rs1_data, 32'hDEADBEEF);
    chk("byp_rs2", b1.ex_rs2_data, 32'hDEADBEEF);
    chk("nobyp_old", b0.ex_rs1_data, 0);
    step(1, 1, f_add(6, 5, 5), 0, 1, 0, 0, 0);
    chk("nobyp_new", b0.ex_rs1_data, 32'hDEADBEEF);

    // x0 stays zero
    step(1, 1, f_add(7, 0, 0), 0, 1, 1, 0,
         32'h12345678);
    chk("x0_byp", b1.ex_rs1_data, 0);
    step(1, 1, f_add(7, 0, 0), 0, 1, 0, 0, 0);
    chk("x0_read", b0.ex_rs1_data, 0);

    // load-use: one stall, one bubble
    step(1, 1, f_lw(3, 1), 0, 1, 0, 0, 0);
    step(1, 1, f_add(4, 3, 2), 0, 1, 0, 0, 0);
    chk("lu_stall", last_ready, 0);
    chk("lu_bubble", b1.ex_valid, 0);
    step(1, 1, f_add(4, 3, 2), 0, 1, 0, 0, 0);
    chk("lu_go", last_ready, 1);
    chk("lu_rs1", b1.ex_rs1, 3);

    // lui after load: rs1 field matches but unused
    step(1, 1, f_lw(3, 1), 0, 1, 0, 0, 0);
    step(1, 1, f_lui(4, 20'h18), 0, 1, 0, 0, 0);
    chk("lui_ready", last_ready, 1);
    chk("lui_rd", b1.ex_rd, 4);

    // back-pressure for three cycles
    step(1, 1, f_add(8, 1, 2), 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, f_add(9, 1, 2), 0, 0, 0, 0, 0);
      chk("bp_ready", last_ready, 0);
      chk("bp_hold", b1.ex_rd, 8);
    end
    step(1, 1, f_add(9, 1, 2), 0, 1, 0, 0, 0);
    chk("bp_resume", last_ready, 1);
    chk("bp_next", b1.ex_rd, 9);

    // flush kills both in-flight instructions
    step(1, 1, f_add(10, 1, 1), 0, 1, 0, 0, 0);
    step(1, 1, f_add(11, 1, 1), 1, 1, 0, 0, 0);
    chk("fl_valid", b1.ex_valid, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    chk("fl_after", b1.ex_valid, 0);

    // flush while EX stalls
    step(1, 1, f_add(10, 1, 1), 0, 1, 0, 0, 0);
    step(1, 1, f_add(11, 1, 1), 1, 0, 0, 0, 0);
    chk("fl_stall", b0.ex_valid, 0);

    // flush against a load-use hazard
    step(1, 1, f_lw(3, 1), 0, 1, 0, 0, 0);
    step(1, 1, f_add(4, 3, 2), 1, 1, 0, 0, 0);
    chk("fl_haz", b1.ex_valid, 0);
    step(1, 1, f_add(4, 3, 2), 0, 1, 0, 0, 0);
    chk("fl_haz_go", last_ready, 1);

    // reset during a hold
    step(1, 1, f_add(12, 1, 1), 0, 1, 0, 0, 0);
    step(1, 1, f_add(13, 1, 1), 0, 0, 0, 0, 0);
    step(0, 1, f_add(13, 1, 1), 0, 0, 0, 0, 0);
    chk("rh_valid", b1.ex_valid, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    chk("rh_after", b1.ex_valid, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 99) < 80,
           rnd_ins(),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)),
           $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
